// File: rtl/xor_acc_sched.sv
// xor_acc_sched: round-robin sequencer that XOR-folds packet-buffer words for one thread job at a time
module xor_acc_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int AW   = 8,
    parameter int LENW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        result,
    output logic                 busy,
    output logic                 mem_rd_en,
    output logic [AW-1:0]        mem_rd_addr,
    input  logic [DW-1:0]        mem_rd_data
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] rr_ptr, sel, idx, gidx;
    logic found;
    logic [LENW-1:0] left, sel_len;
    logic [AW-1:0] addr, sel_addr;
    logic [DW-1:0] acc;
    logic rd_q;
    // scan downward so the requester closest to rr_ptr is the last one written
    always_comb begin
        sel = '0;
        idx = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                sel = idx;
                found = 1'b1;
            end
        end
    end
    assign sel_len = req_len[sel*LENW +: LENW];
    assign sel_addr = req_addr[sel*AW +: AW];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? (sel_len == '0 ? DONE : RUN) : IDLE;
            RUN:     state_nx = left == LENW'(1) ? DRAIN : RUN;
            DRAIN:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt <= '0;
            result <= '0;
            addr <= '0;
            left <= '0;
            acc <= '0;
            rd_q <= 1'b0;
            rr_ptr <= '0;
            gidx <= '0;
        end else begin
            rd_q <= mem_rd_en;
            if (rd_q) acc <= acc ^ mem_rd_data;
            case (state)
                IDLE: if (found) begin
                    gnt <= NREQ'(1) << sel;
                    gidx <= sel;
                    addr <= sel_addr;
                    left <= sel_len;
                    acc <= '0;
                    if (sel_len == '0) result <= '0;
                end
                RUN: begin
                    addr <= addr + AW'(1);
                    left <= left - LENW'(1);
                end
                // last word arrives during DRAIN, so result is ready alongside done
                DRAIN: result <= acc ^ mem_rd_data;
                default: begin
                    gnt <= '0;
                    rr_ptr <= IW'((int'(gidx) + 1) % NREQ);
                end
            endcase
        end
    end
    assign busy = state != IDLE;
    assign mem_rd_en = state == RUN;
    assign mem_rd_addr = addr;
    assign done = state == DONE ? gnt : '0;
endmodule

// File: doc/xor_acc_sched.md
# xor_acc_sched

Sequencer and round-robin arbiter for the shared XOR-accumulate engine in the 2-core/4-thread accelerator. Each hardware thread issues an XORACC job: a start word address and a word count. The block grants one thread at a time and streams the words from the packet buffer read port. It XOR-folds them into a 64-bit accumulator and returns the result to the granted thread with a one-cycle done pulse.

## Interface
Parameters:
- NREQ, 4, number of requesting threads (2 cores x 2 threads)
- DW, 64, data/accumulator width
- AW, 8, packet-buffer word address width
- LENW, 8, job length width, in words

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-thread job request, level
- req_addr  in  NREQ*AW  start word address; thread i uses slice [i*AW +: AW]
- req_len  in  NREQ*LENW  word count; thread i uses slice [i*LENW +: LENW]; 0 is legal
- gnt  out  NREQ  one-hot grant, high for the whole job
- done  out  NREQ  one-cycle completion pulse to the granted thread
- result  out  DW  XOR of all job words; valid with done and held until the next done
- busy  out  1  high in any state other than IDLE
- mem_rd_en  out  1  packet-buffer read strobe
- mem_rd_addr  out  AW  read address
- mem_rd_data  in  DW  read data, valid exactly 1 cycle after mem_rd_en

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, any req high:
  - Select the first requester at or after rr_ptr, searching cyclically upward.
  - Latch that thread's addr and len; clear acc.
  - Set gnt to the selected one-hot.
  - If len==0, go to DONE; otherwise go to RUN.
- RUN:
  - Assert mem_rd_en with mem_rd_addr = current address.
  - Increment the address modulo 2^AW and decrement the remaining count.
  - When the final word is issued, go to DRAIN.
- Accumulation: in every cycle following a mem_rd_en, acc <= acc ^ mem_rd_data. This covers RUN cycles after the first, plus DRAIN.
- DRAIN: absorb the last read data; go to DONE.
- DONE:
  - Pulse done at the granted index; result <= acc.
  - Clear gnt and set rr_ptr = (granted index + 1) mod NREQ.
  - Go to IDLE.
- req is sampled only in IDLE.
  - Deasserting req mid-job is ignored; the job completes and done is still pulsed.
  - A req still high in IDLE after done is treated as a new job.
- req_addr and req_len are sampled only at grant; later changes have no effect.
- Job sources are never interleaved; exactly one job is in flight.

## Timing
- Reset values (rst_n low at a clock edge): state IDLE, gnt=0, done=0, result=0, busy=0, mem_rd_en=0, mem_rd_addr=0, acc=0, rr_ptr=0.
- Reset mid-job aborts the job with no done pulse. Outputs take reset values the next cycle.
- Let the request be sampled in IDLE at cycle 0, with len=N>0:
  - gnt and busy go high at cycle 1.
  - mem_rd_en is high on cycles 1..N, with addresses A..A+N-1 (mod 2^AW).
  - DRAIN occurs at cycle N+1.
  - done and result are valid at cycle N+2; gnt falls at cycle N+3.
- len=0: gnt and done are both high at cycle 1; result=0.
- Back-to-back jobs:
  - The IDLE cycle after DONE is mandatory; the next grant appears 2 cycles after done.
  - Throughput is N+3 cycles per job.
- busy is high from grant through the DONE cycle inclusive.
- Address wraps silently, e.g. FF -> 00 with AW=8.
- Maximum job length is 2^LENW-1 words; no error condition.

## Test plan
- Single job: thread 2 requests, addr=0x10, len=3, memory words 0x1, 0x2, 0x4. Expect gnt=4'b0100 at cycle 1, reads at 0x10/0x11/0x12, done[2] at cycle 5, result=0x7, one idle cycle, busy low afterwards.
- Zero length: thread 1 requests with len=0. Expect gnt[1] and done[1] at cycle 1, result=0, mem_rd_en never asserted.
- Fairness: all four req held high from reset, each len=1. Expect grant order 0,1,2,3,0,..., each done 4 cycles apart. Then drop req[1]: expect order 2,3,0,2,...
- Wrap-around: addr=0xFE, len=3, words A, B, C. Expect read addresses FE, FF, 00 and result A^B^C.
- Request withdrawal: thread 3 drops req one cycle after grant, with len=4. Expect all 4 reads, done[3] pulsed, correct XOR.
- Reset mid-job: assert rst_n low during RUN of a len=8 job. Expect all outputs zero next cycle and no done. A subsequent thread 0 job must complete correctly from acc=0.
